// File: rtl/manchester_tx_framer.sv
// Manchester line framer: preamble, sync word and payload bytes,
// each line bit spread over four clk_link cycles (IEEE 802.3 polarity).
module manchester_tx_framer #(
    parameter int unsigned PREAMBLE_BITS = 40,
    parameter logic [7:0]  SYNC_WORD     = 8'hD5
) (
    input  logic       clk_link,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       manch_out,
    output logic       tx_busy,
    output logic       frame_done
);

    typedef enum logic [1:0] {
        IDLE,
        PREAMBLE,
        SYNC,
        DATA
    } state_t;

    localparam logic [7:0] PRE_LAST = 8'(PREAMBLE_BITS - 1);

    state_t     state;
    state_t     state_nx;
    logic [1:0] phase;
    logic [7:0] bit_cnt;
    logic [7:0] hold_data;
    logic       hold_full;
    logic       hold_full_nx;
    logic [7:0] shift_reg;

    logic accept;
    logic bit_end;
    logic last8;
    logic load;
    logic frame_end;
    logic line_bit;
    logic line_nx;

    assign accept  = tx_valid && tx_ready;
    assign bit_end = (phase == 2'd3);
    assign last8   = bit_end && (bit_cnt == 8'd7);

    // State register
    always_ff @(posedge clk_link) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic; everything but leaving IDLE waits for phase 3
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (hold_full) state_nx = PREAMBLE;
            end
            PREAMBLE: begin
                if (bit_end && bit_cnt == PRE_LAST) state_nx = SYNC;
            end
            SYNC: begin
                if (last8) state_nx = DATA;
            end
            DATA: begin
                if (last8 && !hold_full) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Output decode: current line bit, byte load and end-of-frame
    always_comb begin
        tx_busy   = (state != IDLE);
        load      = 1'b0;
        frame_end = 1'b0;
        line_bit  = 1'b0;
        unique case (state)
            IDLE: begin
                line_bit = 1'b0;
            end
            PREAMBLE: begin
                line_bit = ~bit_cnt[0];
            end
            SYNC: begin
                line_bit = SYNC_WORD[3'd7 - bit_cnt[2:0]];
                load     = last8;
            end
            DATA: begin
                line_bit  = shift_reg[7];
                load      = last8 && hold_full;
                frame_end = last8 && !hold_full;
            end
            default: line_bit = 1'b0;
        endcase
        // Bit 1 goes low then high, bit 0 high then low
        if (state == IDLE) begin
            line_nx = 1'b0;
        end else begin
            line_nx = phase[1] ? line_bit : ~line_bit;
        end
    end

    // Holding register next-full flag
    always_comb begin
        hold_full_nx = hold_full;
        if (accept) begin
            hold_full_nx = 1'b1;
        end else if (load) begin
            hold_full_nx = 1'b0;
        end
    end

    // Phase and bit counters; bit counter restarts on every section change
    always_ff @(posedge clk_link) begin
        if (!rst_n) begin
            phase   <= 2'd0;
            bit_cnt <= 8'd0;
        end else if (state == IDLE) begin
            phase   <= 2'd0;
            bit_cnt <= 8'd0;
        end else begin
            phase <= phase + 2'd1;
            if (bit_end) begin
                if (state_nx != state || load) begin
                    bit_cnt <= 8'd0;
                end else begin
                    bit_cnt <= bit_cnt + 8'd1;
                end
            end
        end
    end

    // Holding register, registered ready flag and payload shifter
    always_ff @(posedge clk_link) begin
        if (!rst_n) begin
            hold_data <= 8'h00;
            hold_full <= 1'b0;
            tx_ready  <= 1'b1;
            shift_reg <= 8'h00;
        end else begin
            hold_full <= hold_full_nx;
            tx_ready  <= ~hold_full_nx;
            if (accept) begin
                hold_data <= tx_data;
            end
            if (load) begin
                shift_reg <= hold_data;
            end else if (state == DATA && bit_end) begin
                shift_reg <= {shift_reg[6:0], 1'b0};
            end
        end
    end

    // Registered line output and end-of-frame pulse
    always_ff @(posedge clk_link) begin
        if (!rst_n) begin
            manch_out  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            manch_out  <= line_nx;
            frame_done <= frame_end;
        end
    end

endmodule

// File: doc/manchester_tx_framer.md
MANCHESTER_TX_FRAMER -- requirements
Module: manchester_tx_framer

Interface
REQ-001 The parameter PREAMBLE_BITS SHALL default to 40 and give the number of preamble bits sent per frame, with a legal range of 33..255.
REQ-002 The parameter SYNC_WORD SHALL default to 8'hD5 and give the start-of-frame delimiter, sent MSB first.
REQ-003 The port clk_link SHALL be an input, 1 bit wide, carrying the 200 MHz link clock; all logic is clocked on its rising edge.
REQ-004 The port rst_n SHALL be an input, 1 bit wide, acting as the reset, which is synchronous and active-low.
REQ-005 The port tx_data SHALL be an input, 8 bits wide, carrying the payload byte, sent MSB first.
REQ-006 The port tx_valid SHALL be an input, 1 bit wide, signalling that tx_data is valid.
REQ-007 The port tx_ready SHALL be an output, 1 bit wide, signalling that the holding register is empty; a byte is accepted on any edge where tx_valid and tx_ready are both 1.
REQ-008 The port manch_out SHALL be an output, 1 bit wide, carrying the registered Manchester line output.
REQ-009 The port tx_busy SHALL be an output, 1 bit wide, high whenever the state is not IDLE.
REQ-010 The port frame_done SHALL be an output, 1 bit wide, pulsing high for 1 cycle when a frame ends.

Function
REQ-011 Each line bit SHALL last exactly 4 clk_link cycles, tracked by a 2-bit phase counter 0..3; phases 0-1 form the first half and phases 2-3 the second half.
REQ-012 Encoding SHALL follow IEEE 802.3: bit 1 is sent low then high; bit 0 is sent high then low; every bit has exactly one mid-bit transition.
REQ-013 The state machine SHALL have the states IDLE, PREAMBLE, SYNC and DATA; all state changes except leaving IDLE occur only at phase 3.
REQ-014 In IDLE, manch_out SHALL be held at 0 with no transitions and the phase counter held at 0.
REQ-015 IDLE SHALL move to PREAMBLE on the edge after the holding register becomes full; manch_out first shows preamble bit 0 exactly 2 edges after the accepting edge.
REQ-016 PREAMBLE SHALL send PREAMBLE_BITS bits of alternating value starting with 1 (1,0,1,0,...), then move to SYNC.
REQ-017 SYNC SHALL send the 8 bits of SYNC_WORD, then move to DATA, loading the holding-register byte into an 8-bit shift register and clearing the holding register.
REQ-018 DATA SHALL send the 8 shift-register bits MSB first.
REQ-019 At phase 3 of the last data bit, if the holding register is full, the next byte SHALL be loaded with no gap and no preamble.
REQ-020 At phase 3 of the last data bit, if the holding register is empty, the state SHALL go to IDLE, frame_done SHALL pulse for 1 cycle and manch_out SHALL return to 0.
REQ-021 tx_ready SHALL be registered and equal to the inverse of the holding-register full flag; an accept and a load in the same cycle are impossible because tx_ready is 0 while the register is full.
REQ-022 Changes to tx_data while tx_valid is 1 and tx_ready is 0 SHALL be ignored; only the value captured on the accepting edge is sent.
REQ-023 A frame of N back-to-back bytes SHALL occupy exactly (PREAMBLE_BITS + 8 + 8N) x 4 cycles of tx_busy high.
REQ-024 The bit and index counters SHALL be 8 bits wide; the preamble bit counter SHALL stop at PREAMBLE_BITS-1 and never wrap.

Reset
REQ-025 While rst_n is 0, the outputs SHALL be manch_out 0, tx_ready 1, tx_busy 0 and frame_done 0, with the state IDLE, phase 0, holding register empty and shift register 8'h00.
REQ-026 A reset asserted mid-frame SHALL abort the frame on the next edge, discard the held and in-flight bytes, and emit no frame_done pulse.

Verification
REQ-027 Reset, then no tx_valid for 1000 cycles -> manch_out stays 0, tx_ready 1, tx_busy 0.
REQ-028 Single byte 8'hA5 with defaults -> tx_busy high for 224 cycles; decoded stream is 40 alternating bits starting 1, then 8'hD5, then 8'hA5; 1 frame_done pulse; line at 0 afterwards.
REQ-029 Three bytes 8'h00, 8'hFF, 8'h3C with tx_valid held high -> tx_busy high for 288 cycles; tx_ready low between accepts; no idle gap between bytes; 1 frame_done pulse.
REQ-030 Transitions check on any frame -> exactly one transition at phase 1->2 of every bit and none inside a half-bit; every half-bit lasts exactly 2 cycles.
REQ-031 rst_n driven low at cycle 100 of a frame -> manch_out 0 and tx_ready 1 on the next edge; no frame_done; a new byte afterwards starts a full preamble.
REQ-032 The output connected to a 4x-oversampling CDR receiver -> the receiver reports lock within the preamble and recovers bytes 8'h5A and 8'hC3 correctly.
